trans_m: RTL and testbench

- Row-wise negation unit of the matrix coprocessor.
- Takes one packed matrix row of signed 8-bit elements and returns the row with every element negated (two's complement).
- Flags any element whose negation overflows.
- Sits in the coprocessor datapath as a single-stage registered operator, fed by the row bus and drained by the result writeback.

---
 rtl/trans_m_pkg.sv | 12 +
 rtl/trans_m_neg_elem.sv | 27 ++
 rtl/trans_m.sv | 58 +++++
 tb/tb_trans_m.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/trans_m_pkg.sv
// Shared constants and element type for the row negation unit (trans_m).
// Element 0 sits at the MSB end of every packed row bus.
package trans_m_pkg;

  localparam int N_ELEM_DEF = 5;
  localparam int ELEM_W_DEF = 8;

  typedef logic signed [ELEM_W_DEF-1:0] elem_t;

  localparam elem_t ELEM_MIN = 8'h80;

endpackage

// File: rtl/trans_m_neg_elem.sv
// Purpose: two's complement negation of one signed element with overflow flag.
// Latency: combinational. Backpressure: none. Optional: TRANS_M_SAT_EN clamps -MIN to +MAX.
module trans_m_neg_elem
  import trans_m_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic [ELEM_W-1:0] i_elem,
  output logic [ELEM_W-1:0] o_neg,
  output logic              o_ovf
);

  localparam logic [ELEM_W-1:0] L_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

  logic [ELEM_W-1:0] w_wrap;

  assign w_wrap = ~i_elem + {{(ELEM_W-1){1'b0}}, 1'b1};
  // Only the most negative value has no positive counterpart.
  assign o_ovf  = (i_elem == L_MIN);

`ifdef TRANS_M_SAT_EN
  assign o_neg = o_ovf ? ~L_MIN : w_wrap;
`else
  assign o_neg = w_wrap;
`endif

endmodule

// File: rtl/trans_m.sv
// Purpose: registered row-wise negation with per-element overflow (TRANS_M_SAT_EN selects saturation).
// Latency: 1 cycle, one row accepted every cycle. Backpressure: none, no ready; outputs hold when idle.
module trans_m
  import trans_m_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [N_ELEM*ELEM_W-1:0] m_1,
  output logic [N_ELEM*ELEM_W-1:0] m_out,
  output logic                     out_valid,
  output logic                     ovf,
  output logic [N_ELEM-1:0]        ovf_elem
);

  logic [N_ELEM*ELEM_W-1:0] w_neg_row;
  logic [N_ELEM-1:0]        w_ovf_elem;

  logic [N_ELEM*ELEM_W-1:0] r_m_out;
  logic                     r_out_valid;
  logic                     r_ovf;
  logic [N_ELEM-1:0]        r_ovf_elem;

  // Lane g maps to element g; flags follow the row bus ordering (element 0 at MSB).
  for (genvar g = 0; g < N_ELEM; g++) begin : g_lane
    localparam int LSB = (N_ELEM - 1 - g) * ELEM_W;
    trans_m_neg_elem #(.ELEM_W(ELEM_W)) u_neg (
      .i_elem (m_1[LSB +: ELEM_W]),
      .o_neg  (w_neg_row[LSB +: ELEM_W]),
      .o_ovf  (w_ovf_elem[N_ELEM-1-g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_out     <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_ovf_elem  <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_m_out    <= w_neg_row;
        r_ovf_elem <= w_ovf_elem;
        r_ovf      <= |w_ovf_elem;
      end
    end
  end

  assign m_out     = r_m_out;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign ovf_elem  = r_ovf_elem;

endmodule

// File: tb/tb_trans_m.sv
// Scoreboard bench for trans_m: expected rows queued at issue, popped by a monitor on out_valid.
module tb_trans_m;
  import trans_m_pkg::*;

  localparam int NE = N_ELEM_DEF;
  localparam int EW = ELEM_W_DEF;
  localparam int RW = NE * EW;

`ifdef TRANS_M_SAT_EN
  localparam elem_t NEG_MIN = 8'h7F;
`else
  localparam elem_t NEG_MIN = ELEM_MIN;
`endif

  typedef struct packed {
    logic [RW-1:0] dat;
    logic          ovf;
    logic [NE-1:0] elem;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [RW-1:0] m_1;
  logic [RW-1:0] m_out;
  logic          out_valid;
  logic          ovf;
  logic [NE-1:0] ovf_elem;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  trans_m dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .m_1       (m_1),
    .m_out     (m_out),
    .out_valid (out_valid),
    .ovf       (ovf),
    .ovf_elem  (ovf_elem)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string name, input exp_t exp);
    n_checks++;
    if (m_out !== exp.dat || ovf !== exp.ovf || ovf_elem !== exp.elem) begin
      n_errors++;
      $display("FAIL %s: got m_out=%h ovf=%b ovf_elem=%b, want m_out=%h ovf=%b ovf_elem=%b",
               name, m_out, ovf, ovf_elem, exp.dat, exp.ovf, exp.elem);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Issue a row and queue its hand-computed result.
  task automatic send(input logic [RW-1:0] row, input logic [RW-1:0] exp_dat,
                      input logic exp_ovf, input logic [NE-1:0] exp_elem);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    m_1      = row;
    e.dat    = exp_dat;
    e.ovf    = exp_ovf;
    e.elem   = exp_elem;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      m_1      = 40'hDEADBEEF55;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got out_valid=1 with m_out=%h, want no output", m_out);
      end else begin
        check_out("row", sb_q.pop_front());
      end
    end
  end

  initial begin
    exp_t zero_e;
    exp_t hold_e;
    zero_e   = '0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    m_1      = 40'h8000000000;
    #1;
    check_out("reset_init", zero_e);
    check_bit("reset_init_vld", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(1);

    send(40'h0103020500, 40'hFFFDFEFB00, 1'b0, 5'b00000);
    send(40'hFFFDFEFB00, 40'h0103020500, 1'b0, 5'b00000);
    send(40'h8000000000, {NEG_MIN, 32'h0}, 1'b1, 5'b10000);
    send(40'h7F81800080, {16'h817F, NEG_MIN, 8'h00, NEG_MIN}, 1'b1, 5'b00101);

    // Mid-run reset with a row in flight: it must be discarded, outputs clear without a clock.
    @(negedge clk);
    in_valid = 1'b1;
    m_1      = 40'h8080808080;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_async", zero_e);
    check_bit("reset_async_vld", out_valid, 1'b0);
    @(negedge clk);
    check_bit("reset_hold_vld", out_valid, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(2);

    send(40'h0103020500, 40'hFFFDFEFB00, 1'b0, 5'b00000);
    check_bit("first_after_reset_pre", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_bit("first_after_reset_vld", out_valid, 1'b1);

    send(40'h0AF6007F01, 40'hF60A0081FF, 1'b0, 5'b00000);
    send(40'h8080808080, {5{NEG_MIN}}, 1'b1, 5'b11111);
    send(40'h02FE80F033, {16'hFE02, NEG_MIN, 16'h10CD}, 1'b1, 5'b00100);
    idle(3);

    hold_e.dat  = {16'hFE02, NEG_MIN, 16'h10CD};
    hold_e.ovf  = 1'b1;
    hold_e.elem = 5'b00100;
    check_out("idle_hold", hold_e);
    check_bit("idle_vld", out_valid, 1'b0);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d rows outstanding, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
